mcycle_ctrl: RTL and testbench
==============================

MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 SHALL have ports: clk input 1, sole clock, rising edge.
REQ-002 SHALL have port reset input 1, asynchronous, active-low.
REQ-003 SHALL have inputs: op 6 (instr[31:26]); funct 6 (instr[5:0]); zero 1 (ALU result ==0); dayuling 1 (ALU operand A signed >0).
REQ-004 SHALL have outputs: pcwr 1, PC load; npcsel 2, 00 PC+4 / 01 branch / 10 jump / 11 jr; irwr 1, IR load.
REQ-005 SHALL have outputs: regwrite 1; regdst 2, 00 rt / 01 rd / 10 r31; wdsel 2, 00 ALU / 01 DM data reg / 10 PC.
REQ-006 SHALL have outputs: memwrite 1; alusrc 1, 0 rt / 1 imm32; aluop 2, 00 add / 01 sub / 10 or / 11 pass-B; extop 2, 00 zero / 01 sign / 10 imm16<<16.
REQ-007 SHALL have outputs: state 4 (current FSM state); instret 32 (retired count); illegal 1 (sticky bad opcode).

Function
REQ-008 SHALL register only state, instret and illegal; all other outputs SHALL be combinational from state, op and funct.
REQ-009 SHALL encode states FETCH=0, DECODE=1, EXEC=2, WB_ALU=3, MADDR=4, MRD=5, WB_MEM=6, MWR=7, BRANCH=8; codes 9-15 SHALL go to FETCH next cycle.
REQ-010 FETCH: irwr=1, pcwr=1, npcsel=00; next DECODE.
REQ-011 DECODE: j -> pcwr=1, npcsel=10, next FETCH.
REQ-012 DECODE: jal (000011) -> pcwr=1, npcsel=10, regwrite=1, regdst=10, wdsel=10, next FETCH.
REQ-013 DECODE: jr (op 0, funct 001000) -> pcwr=1, npcsel=11, next FETCH.
REQ-014 DECODE: addu (funct 100001), subu (100011), ori (001101) and lui (001111) SHALL go to EXEC; lw (100011) and sw (101011) SHALL go to MADDR; beq (000100) SHALL go to BRANCH.
REQ-015 DECODE: any other op/funct SHALL set illegal, produce no write strobe, not increment instret, next FETCH.
REQ-016 EXEC then WB_ALU: addu aluop=00 alusrc=0; subu 01/0; ori 10/1 extop=00; lui 11/1 extop=10.
REQ-017 EXEC: operand controls held; next WB_ALU.
REQ-018 WB_ALU: operand controls held, regwrite=1, wdsel=00, regdst=01 for R-type else 00; next FETCH.
REQ-019 MADDR, MRD, MWR: aluop=00, alusrc=1, extop=01 (held).
REQ-020 MADDR: next MRD for lw, MWR for sw.
REQ-021 MWR: memwrite=1 for exactly one cycle; next FETCH.
REQ-022 MRD: no strobes; next WB_MEM.
REQ-023 WB_MEM: regwrite=1, wdsel=01, regdst=00; next FETCH.
REQ-024 BRANCH, beq: aluop=01, alusrc=0, extop=01, npcsel=01, pcwr=zero.
REQ-025 BRANCH, bgtz: pcwr=dayuling, other controls as beq; next FETCH.
REQ-026 Latency: j/jal/jr 2 cycles; beq/bgtz 3; sw 4; ALU ops 4; lw 5.
REQ-027 instret SHALL increment on every legal-instruction transition into FETCH; 0xFFFFFFFF wraps to 0.
REQ-028 Every strobe (pcwr, irwr, regwrite, memwrite) SHALL be high at most one cycle per state visit; memwrite and regwrite never high together.

Reset
REQ-029 reset low SHALL immediately force state=FETCH, instret=0, illegal=0, asynchronously, mid-instruction included.
REQ-030 While reset is low, pcwr, irwr, regwrite and memwrite SHALL be 0.
REQ-031 The first FETCH SHALL execute on the first rising clk edge after reset deasserts.

Configuration
REQ-032 Macro MCYCLE_CTRL_BGTZ_EN defined: op 000111 (bgtz) SHALL decode to BRANCH per REQ-025.
REQ-033 Macro MCYCLE_CTRL_BGTZ_EN undefined: op 000111 SHALL be illegal per REQ-015; dayuling SHALL be ignored.

Verification
REQ-034 addu stream (op 0, funct 100001): state sequence 0,1,2,3,0; regwrite=1 only in state 3 with regdst=01; instret 0->1.
REQ-035 lw then sw: lw states 0,1,4,5,6 with wdsel=01 in 6; sw states 0,1,4,7 with memwrite=1 only in 7; instret=2.
REQ-036 beq: zero=1 -> pcwr=1, npcsel=01 in state 8; zero=0 -> pcwr=0; both return to FETCH.
REQ-037 jal: DECODE gives pcwr=1, npcsel=10, regwrite=1, regdst=10, wdsel=10; op 111111 -> illegal=1, instret unchanged, back to FETCH.
REQ-038 reset low during MWR: state=0 and memwrite=0 without clock edge; instret preset to 0xFFFFFFFF (force) wraps to 0 after one instruction.
REQ-039 bgtz, dayuling=1: macro defined -> pcwr=1 in state 8; undefined -> illegal=1, no pcwr.

Source files
------------

// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl -- multi-cycle MIPS-subset controller.
//
// Walks each instruction through FETCH/DECODE and then the execute,
// memory, branch or write-back states its class needs, driving the
// datapath control lines from the current state plus the op/funct
// fields. Only state, instret and illegal are stored; every other output
// is decoded combinationally.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low
//   op, funct  instr[31:26], instr[5:0]
//   zero       ALU result == 0      (beq condition)
//   dayuling   ALU operand A > 0    (bgtz condition)
//   pcwr, npcsel, irwr              PC / IR load controls
//   regwrite, regdst, wdsel         register-file write controls
//   memwrite                        data-memory write strobe
//   alusrc, aluop, extop            ALU operand / immediate controls
//   state      current FSM state code
//   instret    retired legal instruction count (wraps)
//   illegal    sticky flag, set when an unknown op/funct is decoded
//
// Configuration
//   MCYCLE_CTRL_BGTZ_EN  when defined, op 000111 (bgtz) is decoded as a
//                        branch on dayuling; otherwise it is illegal.

module mcycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        dayuling,
  output logic        pcwr,
  output logic [1:0]  npcsel,
  output logic        irwr,
  output logic        regwrite,
  output logic [1:0]  regdst,
  output logic [1:0]  wdsel,
  output logic        memwrite,
  output logic        alusrc,
  output logic [1:0]  aluop,
  output logic [1:0]  extop,
  output logic [3:0]  state,
  output logic [31:0] instret,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_WB_ALU = 4'd3,
    S_MADDR  = 4'd4,
    S_MRD    = 4'd5,
    S_WB_MEM = 4'd6,
    S_MWR    = 4'd7,
    S_BRANCH = 4'd8
  } state_e;

  // Opcode / funct encodings
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Control field encodings
  localparam logic [1:0] NPC_PC4 = 2'b00, NPC_BR  = 2'b01, NPC_J   = 2'b10, NPC_JR = 2'b11;
  localparam logic [1:0] RD_RT   = 2'b00, RD_RD   = 2'b01, RD_R31  = 2'b10;
  localparam logic [1:0] WD_ALU  = 2'b00, WD_DM   = 2'b01, WD_PC   = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_OR  = 2'b10, ALU_B  = 2'b11;
  localparam logic [1:0] EXT_Z   = 2'b00, EXT_S   = 2'b01, EXT_HI  = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        illegal_q, illegal_d;

  // ---------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------
  logic is_rtype, is_addu, is_subu, is_jr, is_j, is_jal;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_bgtz;
  logic is_alu, is_mem, is_br, br_take;

  assign is_rtype = (op == OP_RTYPE);
  assign is_addu  = is_rtype && (funct == FN_ADDU);
  assign is_subu  = is_rtype && (funct == FN_SUBU);
  assign is_jr    = is_rtype && (funct == FN_JR);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  assign is_ori   = (op == OP_ORI);
  assign is_lui   = (op == OP_LUI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);

`ifdef MCYCLE_CTRL_BGTZ_EN
  assign is_bgtz  = (op == OP_BGTZ);
  assign br_take  = is_beq ? zero : (is_bgtz ? dayuling : 1'b0);
`else
  // bgtz is not decoded, so its condition input has no consumer.
  logic unused_dayuling;
  assign unused_dayuling = dayuling;
  assign is_bgtz  = 1'b0;
  assign br_take  = is_beq ? zero : 1'b0;
`endif

  assign is_alu = is_addu | is_subu | is_ori | is_lui;
  assign is_mem = is_lw | is_sw;
  assign is_br  = is_beq | is_bgtz;

  // ALU operand controls for the arithmetic class; held through EXEC and
  // WB_ALU so the ALU result stays stable while it is written back.
  logic [1:0] alu_aluop, alu_extop;
  logic       alu_alusrc;

  always_comb begin
    alu_aluop  = ALU_ADD;
    alu_alusrc = 1'b0;
    alu_extop  = EXT_Z;
    if (is_subu) begin
      alu_aluop = ALU_SUB;
    end else if (is_ori) begin
      alu_aluop  = ALU_OR;
      alu_alusrc = 1'b1;
    end else if (is_lui) begin
      alu_aluop  = ALU_B;
      alu_alusrc = 1'b1;
      alu_extop  = EXT_HI;
    end
  end

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and control decode
  // ---------------------------------------------------------------------
  logic pcwr_c, irwr_c, regwrite_c, memwrite_c, retire;

  always_comb begin
    state_d    = S_FETCH;
    illegal_d  = illegal_q;
    retire     = 1'b0;
    pcwr_c     = 1'b0;
    irwr_c     = 1'b0;
    regwrite_c = 1'b0;
    memwrite_c = 1'b0;
    npcsel     = NPC_PC4;
    regdst     = RD_RT;
    wdsel      = WD_ALU;
    alusrc     = 1'b0;
    aluop      = ALU_ADD;
    extop      = EXT_Z;

    case (state_q)
      S_FETCH: begin
        irwr_c  = 1'b1;
        pcwr_c  = 1'b1;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        if (is_j || is_jal) begin
          pcwr_c = 1'b1;
          npcsel = NPC_J;
          retire = 1'b1;
          if (is_jal) begin
            regwrite_c = 1'b1;
            regdst     = RD_R31;
            wdsel      = WD_PC;
          end
        end else if (is_jr) begin
          pcwr_c = 1'b1;
          npcsel = NPC_JR;
          retire = 1'b1;
        end else if (is_alu) begin
          state_d = S_EXEC;
        end else if (is_mem) begin
          state_d = S_MADDR;
        end else if (is_br) begin
          state_d = S_BRANCH;
        end else begin
          // Unknown encoding: flag it and drop the instruction silently.
          illegal_d = 1'b1;
        end
      end

      S_EXEC: begin
        aluop   = alu_aluop;
        alusrc  = alu_alusrc;
        extop   = alu_extop;
        state_d = S_WB_ALU;
      end

      S_WB_ALU: begin
        aluop      = alu_aluop;
        alusrc     = alu_alusrc;
        extop      = alu_extop;
        regwrite_c = 1'b1;
        wdsel      = WD_ALU;
        regdst     = is_rtype ? RD_RD : RD_RT;
        retire     = 1'b1;
      end

      S_MADDR: begin
        aluop   = ALU_ADD;
        alusrc  = 1'b1;
        extop   = EXT_S;
        state_d = is_sw ? S_MWR : S_MRD;
      end

      S_MRD: begin
        aluop   = ALU_ADD;
        alusrc  = 1'b1;
        extop   = EXT_S;
        state_d = S_WB_MEM;
      end

      S_WB_MEM: begin
        regwrite_c = 1'b1;
        wdsel      = WD_DM;
        regdst     = RD_RT;
        retire     = 1'b1;
      end

      S_MWR: begin
        aluop      = ALU_ADD;
        alusrc     = 1'b1;
        extop      = EXT_S;
        memwrite_c = 1'b1;
        retire     = 1'b1;
      end

      S_BRANCH: begin
        aluop  = ALU_SUB;
        alusrc = 1'b0;
        extop  = EXT_S;
        npcsel = NPC_BR;
        pcwr_c = br_take;
        retire = 1'b1;
      end

      // Unused codes recover to FETCH without retiring anything.
      default: state_d = S_FETCH;
    endcase
  end

  assign instret_d = instret_q + {31'd0, retire};

  // Strobes are gated by reset so nothing is written while it is held,
  // even though FETCH (the reset state) would otherwise assert them.
  assign pcwr     = pcwr_c     & reset;
  assign irwr     = irwr_c     & reset;
  assign regwrite = regwrite_c & reset;
  assign memwrite = memwrite_c & reset;

  assign state    = state_q;
  assign instret  = instret_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed testbench for mcycle_ctrl. An instruction-level model lists,
// for each instruction class, the state path and the control values of
// every step; a compare process checks the DUT against it on each
// falling edge. A few literal checks pin the model's counters.

module tb_mcycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  op = 6'd0, funct = 6'd0;
  logic        zero = 1'b0, dayuling = 1'b0;
  logic        pcwr, irwr, regwrite, memwrite, alusrc, illegal;
  logic [1:0]  npcsel, regdst, wdsel, aluop, extop;
  logic [3:0]  state;
  logic [31:0] instret;

  mcycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .dayuling(dayuling), .pcwr(pcwr), .npcsel(npcsel), .irwr(irwr),
    .regwrite(regwrite), .regdst(regdst), .wdsel(wdsel),
    .memwrite(memwrite), .alusrc(alusrc), .aluop(aluop), .extop(extop),
    .state(state), .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef enum int {C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ,
                    C_BGTZ, C_J, C_JAL, C_JR, C_ILL} cls_e;

  typedef struct {
    logic [3:0] st;
    logic       pcwr, irwr, regwrite, memwrite, alusrc;
    logic [1:0] npcsel, regdst, wdsel, aluop, extop;
  } exp_t;

  int          checks = 0, errors = 0;
  logic        chk_en = 1'b0;
  exp_t        cur;
  logic [31:0] m_instret = 32'd0;
  logic        m_illegal = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic cls_e classify(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'd0) begin
      case (f)
        6'b100001: return C_ADDU;
        6'b100011: return C_SUBU;
        6'b001000: return C_JR;
        default:   return C_ILL;
      endcase
    end
    case (o)
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      6'b000100: return C_BEQ;
`ifdef MCYCLE_CTRL_BGTZ_EN
      6'b000111: return C_BGTZ;
`endif
      6'b001101: return C_ORI;
      6'b001111: return C_LUI;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic int ilen(input cls_e c);
    case (c)
      C_LW:                          return 5;
      C_SW, C_ADDU, C_SUBU,
      C_ORI, C_LUI:                  return 4;
      C_BEQ, C_BGTZ:                 return 3;
      default:                       return 2;
    endcase
  endfunction

  // Expected outputs at step k (0 = FETCH) of an instruction of class c.
  function automatic exp_t model(input cls_e c, input int k, input logic z, input logic d);
    exp_t e;
    logic [3:0] path [5];
    e = '{default: '0};
    path = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
    case (c)
      C_ADDU, C_SUBU, C_ORI, C_LUI: path = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
      C_LW:                         path = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6};
      C_SW:                         path = '{4'd0, 4'd1, 4'd4, 4'd7, 4'd0};
      C_BEQ, C_BGTZ:                path = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd0};
      default: ;
    endcase
    e.st = path[k];
    if (k == 0) begin
      e.irwr = 1'b1; e.pcwr = 1'b1;
    end else if (k == 1) begin
      case (c)
        C_J:   begin e.pcwr = 1'b1; e.npcsel = 2'd2; end
        C_JAL: begin e.pcwr = 1'b1; e.npcsel = 2'd2; e.regwrite = 1'b1;
                     e.regdst = 2'd2; e.wdsel = 2'd2; end
        C_JR:  begin e.pcwr = 1'b1; e.npcsel = 2'd3; end
        default: ;
      endcase
    end else begin
      case (c)
        C_ADDU, C_SUBU, C_ORI, C_LUI: begin
          case (c)
            C_SUBU: e.aluop = 2'd1;
            C_ORI:  begin e.aluop = 2'd2; e.alusrc = 1'b1; end
            C_LUI:  begin e.aluop = 2'd3; e.alusrc = 1'b1; e.extop = 2'd2; end
            default: ;
          endcase
          if (k == 3) begin
            e.regwrite = 1'b1;
            e.regdst = (c == C_ADDU || c == C_SUBU) ? 2'd1 : 2'd0;
          end
        end
        C_LW, C_SW: begin
          if (k < 4) begin e.alusrc = 1'b1; e.extop = 2'd1; end
          if (c == C_LW && k == 4) begin e.regwrite = 1'b1; e.wdsel = 2'd1; end
          if (c == C_SW && k == 3) e.memwrite = 1'b1;
        end
        C_BEQ, C_BGTZ: begin
          e.aluop = 2'd1; e.extop = 2'd1; e.npcsel = 2'd1;
          e.pcwr = (c == C_BEQ) ? z : d;
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",    state,    cur.st);
      chk("pcwr",     pcwr,     cur.pcwr);
      chk("npcsel",   npcsel,   cur.npcsel);
      chk("irwr",     irwr,     cur.irwr);
      chk("regwrite", regwrite, cur.regwrite);
      chk("regdst",   regdst,   cur.regdst);
      chk("wdsel",    wdsel,    cur.wdsel);
      chk("memwrite", memwrite, cur.memwrite);
      chk("alusrc",   alusrc,   cur.alusrc);
      chk("aluop",    aluop,    cur.aluop);
      chk("extop",    extop,    cur.extop);
      chk("instret",  instret,  m_instret);
      chk("illegal",  illegal,  m_illegal);
    end
  end

  // Runs one instruction starting in FETCH; returns just after the edge
  // that re-enters FETCH.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input logic z, input logic d);
    cls_e c;
    c = classify(o, f);
    op = o; funct = f; zero = z; dayuling = d;
    cur = model(c, 0, z, d);
    chk_en = 1'b1;
    for (int k = 1; k < ilen(c); k++) begin
      @(posedge clk); #1;
      cur = model(c, k, z, d);
    end
    @(posedge clk); #1;
    if (c == C_ILL) m_illegal = 1'b1;
    else            m_instret = m_instret + 32'd1;
    cur = model(c, 0, z, d);
  endtask

  initial begin
    // Reset held across several edges
    #12;
    chk("rst_state",    state,    32'd0);
    chk("rst_instret",  instret,  32'd0);
    chk("rst_illegal",  illegal,  32'd0);
    chk("rst_pcwr",     pcwr,     32'd0);
    chk("rst_irwr",     irwr,     32'd0);
    chk("rst_regwrite", regwrite, 32'd0);
    chk("rst_memwrite", memwrite, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    run_instr(6'b000000, 6'b100001, 1'b0, 1'b0);   // addu
    chk("lit_instret_addu", instret, 32'd1);
    run_instr(6'b000000, 6'b100011, 1'b0, 1'b0);   // subu
    run_instr(6'b001101, 6'b010101, 1'b0, 1'b0);   // ori
    run_instr(6'b001111, 6'b000000, 1'b0, 1'b0);   // lui
    run_instr(6'b100011, 6'b000000, 1'b0, 1'b0);   // lw
    run_instr(6'b101011, 6'b000000, 1'b0, 1'b0);   // sw
    chk("lit_instret_sw", instret, 32'd6);
    run_instr(6'b000100, 6'b000000, 1'b1, 1'b0);   // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0, 1'b1);   // beq not taken
    run_instr(6'b000010, 6'b000000, 1'b0, 1'b0);   // j
    run_instr(6'b000011, 6'b000000, 1'b0, 1'b0);   // jal
    run_instr(6'b000000, 6'b001000, 1'b0, 1'b0);   // jr
    chk("lit_illegal_clean", illegal, 32'd0);
    run_instr(6'b111111, 6'b000000, 1'b0, 1'b0);   // bad opcode
    chk("lit_illegal_set",   illegal, 32'd1);
    chk("lit_instret_ill",   instret, 32'd11);
    run_instr(6'b000000, 6'b000000, 1'b0, 1'b0);   // bad funct
    run_instr(6'b000111, 6'b000000, 1'b0, 1'b1);   // bgtz, A>0
    run_instr(6'b000111, 6'b000000, 1'b1, 1'b0);   // bgtz, A<=0

    // Reset asserted in the middle of MWR, away from any clock edge
    chk_en = 1'b0;
    op = 6'b101011; funct = 6'd0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mwr_state",    state,    32'd7);
    chk("mwr_memwrite", memwrite, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_state",    state,    32'd0);
    chk("arst_memwrite", memwrite, 32'd0);
    chk("arst_pcwr",     pcwr,     32'd0);
    chk("arst_irwr",     irwr,     32'd0);
    chk("arst_instret",  instret,  32'd0);
    chk("arst_illegal",  illegal,  32'd0);
    m_instret = 32'd0;
    m_illegal = 1'b0;
    @(posedge clk); #1;
    chk("arst_hold_state", state, 32'd0);
    reset = 1'b1;

    // Counter wrap
    #1 force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    m_instret = 32'hFFFF_FFFF;
    chk("lit_instret_forced", instret, 32'hFFFF_FFFF);
    run_instr(6'b000000, 6'b100001, 1'b0, 1'b0);   // addu
    chk("lit_instret_wrap", instret, 32'd0);
    run_instr(6'b100011, 6'b000000, 1'b0, 1'b0);   // lw after wrap
    chk("lit_instret_post", instret, 32'd1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
